inst_cache: RTL and testbench

- Direct-mapped, read-only instruction cache between the instruction unit and the memory unit's instruction-fetch port.
- Hits return a word without touching memory. Misses refill a full line one word at a time through the memory unit's word-level request/ready handshake.
- Honours the ROB `clear` (mispredict flush) and the global `rdy_in` pause.

---
 rtl/inst_cache_pkg.sv | 18 +
 rtl/inst_cache_if.sv | 24 ++
 rtl/icache_line_array.sv | 59 +++++
 rtl/inst_cache.sv | 177 +++++++++++++++++
 tb/tb_inst_cache.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_cache_pkg.sv
// Shared constants and FSM state encoding for the instruction cache.
package inst_cache_pkg;

    localparam int ICACHE_INDEX_BIT  = 4;
    localparam int ICACHE_OFFSET_BIT = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP   = 2'd1,
        REFILL = 2'd2
    } state_t;

    // Tag width left over after the byte, word-offset and index fields.
    function automatic int tag_bits(input int index_bit, input int offset_bit);
        return 32 - 2 - offset_bit - index_bit;
    endfunction

endpackage

// File: rtl/inst_cache_if.sv
// Fetch-side and refill-side handshake signals of the instruction cache.
// slave: the cache itself; master: the instruction unit plus memory unit.
interface inst_cache_if;

    logic        fetch_req;
    logic [31:0] fetch_pc;
    logic        fetch_ready;
    logic [31:0] fetch_inst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_data;

    modport master (
        output fetch_req, fetch_pc, mem_ready, mem_data,
        input  fetch_ready, fetch_inst, mem_req, mem_addr
    );

    modport slave (
        input  fetch_req, fetch_pc, mem_ready, mem_data,
        output fetch_ready, fetch_inst, mem_req, mem_addr
    );

endinterface

// File: rtl/icache_line_array.sv
// Tag/valid/data storage for the direct-mapped instruction cache.
// One combinational read port (index, offset) and one write port.
// Only the valid bits are reset; tags and data are qualified by valid.
module icache_line_array
    import inst_cache_pkg::*;
#(
    parameter int INDEX_BIT  = ICACHE_INDEX_BIT,
    parameter int OFFSET_BIT = ICACHE_OFFSET_BIT,
    parameter int TAG_BIT    = tag_bits(ICACHE_INDEX_BIT, ICACHE_OFFSET_BIT)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [INDEX_BIT-1:0]  rd_index,
    input  logic [OFFSET_BIT-1:0] rd_offset,
    output logic                  rd_valid,
    output logic [TAG_BIT-1:0]    rd_tag,
    output logic [31:0]           rd_data,
    input  logic                  wr_en,
    input  logic [INDEX_BIT-1:0]  wr_index,
    input  logic [OFFSET_BIT-1:0] wr_offset,
    input  logic [31:0]           wr_data,
    input  logic [TAG_BIT-1:0]    wr_tag,
    input  logic                  set_valid,
    input  logic                  clr_valid
);

    localparam int LINES = 1 << INDEX_BIT;
    localparam int WORDS = 1 << OFFSET_BIT;

    logic [LINES-1:0]   valid_q;
    logic [TAG_BIT-1:0] tag_q  [LINES];
    logic [31:0]        data_q [LINES*WORDS];

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[{rd_index, rd_offset}];

    // Valid bits: cleared when a refill starts, set when its last word lands.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_q <= '0;
        end else if (clr_valid) begin
            valid_q[wr_index] <= 1'b0;
        end else if (set_valid) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    // Tag and word storage.
    always_ff @(posedge clk_in) begin
        if (set_valid) begin
            tag_q[wr_index] <= wr_tag;
        end
        if (wr_en) begin
            data_q[{wr_index, wr_offset}] <= wr_data;
        end
    end

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache: hits answer from the line
// array, misses refill a whole line one word at a time from memory.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
//
// state  | meaning
// IDLE   | waiting for a fetch; lookup happens here
// RESP   | fetch_inst valid, fetch_ready pulses unless flushed
// REFILL | requesting words of the captured line from memory
module inst_cache
    import inst_cache_pkg::*;
#(
    parameter int INDEX_BIT  = ICACHE_INDEX_BIT,
    parameter int OFFSET_BIT = ICACHE_OFFSET_BIT
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear,
    inst_cache_if.slave bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int TAG_BIT = tag_bits(INDEX_BIT, OFFSET_BIT);
    localparam logic [OFFSET_BIT-1:0] LAST_WORD = '1;

    state_t                state_q, state_d;
    logic [OFFSET_BIT-1:0] cnt_q, cnt_d;
    logic [INDEX_BIT-1:0]  cap_index_q, cap_index_d;
    logic [TAG_BIT-1:0]    cap_tag_q, cap_tag_d;
    logic [31:0]           inst_q, inst_d;

    logic [TAG_BIT-1:0]    pc_tag;
    logic [INDEX_BIT-1:0]  pc_index;
    logic [OFFSET_BIT-1:0] pc_offset;

    logic                  rd_valid;
    logic [TAG_BIT-1:0]    rd_tag;
    logic [31:0]           rd_data;
    logic                  hit;

    logic                  arr_wr_en;
    logic                  arr_set_valid;
    logic                  arr_clr_valid;
    logic [INDEX_BIT-1:0]  arr_wr_index;
    logic                  take_hit;
    logic                  take_miss;

    logic                  unused_pc_bits;

    assign pc_tag         = bus.fetch_pc[31:32-TAG_BIT];
    assign pc_index       = bus.fetch_pc[2+OFFSET_BIT+INDEX_BIT-1:2+OFFSET_BIT];
    assign pc_offset      = bus.fetch_pc[2+OFFSET_BIT-1:2];
    assign unused_pc_bits = ^bus.fetch_pc[1:0];

    assign hit = rd_valid && (rd_tag == pc_tag);

    // While paused nothing may be written, so every array strobe is qualified by rdy_in.
    icache_line_array #(
        .INDEX_BIT  (INDEX_BIT),
        .OFFSET_BIT (OFFSET_BIT),
        .TAG_BIT    (TAG_BIT)
    ) u_lines (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .rd_index  (pc_index),
        .rd_offset (pc_offset),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .wr_en     (rdy_in & arr_wr_en),
        .wr_index  (arr_wr_index),
        .wr_offset (cnt_q),
        .wr_data   (bus.mem_data),
        .wr_tag    (cap_tag_q),
        .set_valid (rdy_in & arr_set_valid),
        .clr_valid (rdy_in & arr_clr_valid)
    );

    // Next-state, lookup and refill control.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cap_index_d   = cap_index_q;
        cap_tag_d     = cap_tag_q;
        inst_d        = inst_q;
        arr_wr_en     = 1'b0;
        arr_set_valid = 1'b0;
        arr_clr_valid = 1'b0;
        arr_wr_index  = cap_index_q;
        take_hit      = 1'b0;
        take_miss     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.fetch_req && !clear) begin
                    if (hit) begin
                        state_d  = RESP;
                        inst_d   = rd_data;
                        take_hit = 1'b1;
                    end else begin
                        // The victim line is invalidated now so a half-filled line never hits.
                        state_d       = REFILL;
                        cap_index_d   = pc_index;
                        cap_tag_d     = pc_tag;
                        cnt_d         = '0;
                        arr_clr_valid = 1'b1;
                        arr_wr_index  = pc_index;
                        take_miss     = 1'b1;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            REFILL: begin
                // A flush does not stop the refill; the memory unit may be mid-transaction.
                if (bus.mem_ready) begin
                    arr_wr_en = 1'b1;
                    cnt_d     = cnt_q + OFFSET_BIT'(1);
                    if (cnt_q == LAST_WORD) begin
                        arr_set_valid = 1'b1;
                        state_d       = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter, captured line address and instruction register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cap_index_q <= '0;
            cap_tag_q   <= '0;
            inst_q      <= '0;
        end else if (rdy_in) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cap_index_q <= cap_index_d;
            cap_tag_q   <= cap_tag_d;
            inst_q      <= inst_d;
        end
    end

    assign bus.mem_req     = (state_q == REFILL);
    assign bus.mem_addr    = {cap_tag_q, cap_index_q, cnt_q, 2'b00};
    assign bus.fetch_ready = (state_q == RESP) && !clear;
    assign bus.fetch_inst  = inst_q;

`ifdef ICACHE_STATS_EN
    // Saturating hit/miss event counters.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (rdy_in) begin
            if (take_hit && (hit_cnt != 32'hFFFF_FFFF)) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (take_miss && (miss_cnt != 32'hFFFF_FFFF)) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`else
    logic unused_stats;
    assign unused_stats = take_hit ^ take_miss;
`endif

endmodule

// File: tb/tb_inst_cache.sv
// Self-checking bench for inst_cache: a table of directed fetches, hand
// sequences for flush/pause/reset corners, then random fetches checked
// against a direct-mapped lookup model with a deterministic memory image.
module tb_inst_cache;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;
    logic clear;

    inst_cache_if bus ();

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    inst_cache dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .clear  (clear),
        .bus    (bus)
`ifdef ICACHE_STATS_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [31:0] pc;
        bit          exp_miss;
    } vec_t;

    int          n_chk = 0;
    int          n_fail = 0;
    int          rdy_seen;
    int          req_cycles;
    int          wait_cnt;
    bit          resp_en;
    bit          rand_lat;
    logic [31:0] last_inst;
    logic [31:0] cur_pc;
    logic [31:0] addr_q[$];

    bit          mv [16];
    logic [23:0] mt [16];

    vec_t        vecs [10];

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s pc=%h: got %h expected %h", name, cur_pc, act, exp);
        end
    endtask

    // Expected hit/miss from a plain direct-mapped lookup, then record the access.
    task automatic model_access(input logic [31:0] pc, output bit miss);
        int idx;
        idx  = int'(pc[7:4]);
        miss = !(mv[idx] && mt[idx] == pc[31:8]);
        mv[idx] = 1'b1;
        mt[idx] = pc[31:8];
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            mv[i] = 1'b0;
            mt[i] = '0;
        end
    endtask

    // One cycle: sample at the falling edge, then act as the memory unit.
    task automatic tick();
        @(negedge clk_in);
        bus.mem_ready = 1'b0;
        if (bus.fetch_ready) begin
            rdy_seen++;
            last_inst = bus.fetch_inst;
        end
        if (bus.mem_req) begin
            req_cycles++;
            if (resp_en) begin
                if (wait_cnt == 0) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_data  = mem_fn(bus.mem_addr);
                    addr_q.push_back(bus.mem_addr);
                    wait_cnt = rand_lat ? int'($urandom_range(0, 2)) : 0;
                end else begin
                    wait_cnt--;
                end
            end
        end
    endtask

    task automatic start_fetch(input logic [31:0] pc);
        cur_pc = pc;
        addr_q.delete();
        rdy_seen   = 0;
        req_cycles = 0;
        bus.fetch_req = 1'b1;
        bus.fetch_pc  = pc;
    endtask

    task automatic run_fetch(input logic [31:0] pc, input bit exp_miss);
        int lat;
        logic [31:0] base;
        base = pc & 32'hFFFF_FFF0;
        lat  = 0;
        start_fetch(pc);
        while (rdy_seen == 0 && lat < 200) begin
            tick();
            lat++;
        end
        bus.fetch_req = 1'b0;
        check("fetch_pulse", rdy_seen, 1);
        check("fetch_inst", last_inst, mem_fn(pc));
        check("refill_words", addr_q.size(), exp_miss ? 4 : 0);
        foreach (addr_q[i]) check("refill_addr", addr_q[i], base + 32'(i) * 4);
        if (!exp_miss) begin
            check("hit_latency", lat, 1);
            check("hit_mem_req", req_cycles, 0);
        end
        tick();
        check("idle_mem_req", {31'b0, bus.mem_req}, 0);
        check("inst_hold", bus.fetch_inst, mem_fn(pc));
        check("single_pulse", rdy_seen, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  guard;
        bit  m;

        vecs[0] = '{pc: 32'h0000_0000, exp_miss: 1'b1};
        vecs[1] = '{pc: 32'h0000_0004, exp_miss: 1'b0};
        vecs[2] = '{pc: 32'h0000_0008, exp_miss: 1'b0};
        vecs[3] = '{pc: 32'h0000_000C, exp_miss: 1'b0};
        vecs[4] = '{pc: 32'h0000_0100, exp_miss: 1'b1};
        vecs[5] = '{pc: 32'h0000_010C, exp_miss: 1'b0};
        vecs[6] = '{pc: 32'h0000_0000, exp_miss: 1'b1};
        vecs[7] = '{pc: 32'h0000_0104, exp_miss: 1'b1};
        vecs[8] = '{pc: 32'h0000_0010, exp_miss: 1'b1};
        vecs[9] = '{pc: 32'h0000_001C, exp_miss: 1'b0};

        cur_pc        = '0;
        last_inst     = '0;
        wait_cnt      = 0;
        resp_en       = 1'b1;
        rand_lat      = 1'b0;
        rst_in        = 1'b1;
        rdy_in        = 1'b1;
        clear         = 1'b0;
        bus.fetch_req = 1'b0;
        bus.fetch_pc  = '0;
        bus.mem_ready = 1'b0;
        bus.mem_data  = '0;
        model_reset();

        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        check("rst_fetch_ready", {31'b0, bus.fetch_ready}, 0);
        check("rst_mem_req", {31'b0, bus.mem_req}, 0);
        check("rst_fetch_inst", bus.fetch_inst, 0);
`ifdef ICACHE_STATS_EN
        check("rst_hit_cnt", hit_cnt, 0);
        check("rst_miss_cnt", miss_cnt, 0);
`endif

        // Directed table: cold miss, hits in the line, conflict evictions.
        for (int v = 0; v < 10; v++) begin
            model_access(vecs[v].pc, m);
            run_fetch(vecs[v].pc, vecs[v].exp_miss);
`ifdef ICACHE_STATS_EN
            if (v == 2) begin
                check("stats_hit_cnt", hit_cnt, 3);
                check("stats_miss_cnt", miss_cnt, 1);
            end
`endif
        end

        // Flush after the 2nd refill word: refill completes, no pulse.
        rand_lat = 1'b0;
        wait_cnt = 0;
        start_fetch(32'h40);
        guard = 0;
        while (addr_q.size() < 2 && guard < 20) begin
            tick();
            guard++;
        end
        check("clr_two_words", addr_q.size(), 2);
        tick();
        clear = 1'b1;
        bus.fetch_req = 1'b0;
        tick();
        clear = 1'b0;
        repeat (10) tick();
        check("clr_words", addr_q.size(), 4);
        foreach (addr_q[i]) check("clr_addr", addr_q[i], 32'h40 + 32'(i) * 4);
        check("clr_no_pulse", rdy_seen, 0);
        model_access(32'h40, m);
        run_fetch(32'h44, 1'b0);

        // Flush in the response cycle suppresses fetch_ready.
        cur_pc = 32'h48;
        bus.fetch_req = 1'b1;
        bus.fetch_pc  = 32'h48;
        @(negedge clk_in);
        clear = 1'b1;
        bus.fetch_req = 1'b0;
        #1;
        check("resp_clear_pulse", {31'b0, bus.fetch_ready}, 0);
        @(negedge clk_in);
        clear = 1'b0;
        #1;
        check("resp_clear_after", {31'b0, bus.fetch_ready}, 0);
        check("resp_clear_mem_req", {31'b0, bus.mem_req}, 0);
        run_fetch(32'h48, 1'b0);

        // Pause for 3 cycles after the 1st refill word; junk mem_ready is ignored.
        start_fetch(32'h300);
        guard = 0;
        while (addr_q.size() == 0 && guard < 20) begin
            tick();
            guard++;
        end
        check("pause_first", addr_q.size(), 1);
        resp_en = 1'b0;
        tick();
        check("pause_addr_pre", bus.mem_addr, 32'h304);
        rdy_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.mem_ready = 1'b1;
            bus.mem_data  = 32'hDEAD_BEEF;
            @(negedge clk_in);
            check("pause_mem_req", {31'b0, bus.mem_req}, 1);
            check("pause_mem_addr", bus.mem_addr, 32'h304);
            check("pause_no_pulse", {31'b0, bus.fetch_ready}, 0);
        end
        bus.mem_ready = 1'b0;
        rdy_in  = 1'b1;
        resp_en = 1'b1;
        guard = 0;
        while (rdy_seen == 0 && guard < 50) begin
            tick();
            guard++;
        end
        bus.fetch_req = 1'b0;
        check("pause_pulse", rdy_seen, 1);
        check("pause_words", addr_q.size(), 4);
        foreach (addr_q[i]) check("pause_addr", addr_q[i], 32'h300 + 32'(i) * 4);
        check("pause_inst", last_inst, mem_fn(32'h300));
        tick();
        model_access(32'h300, m);
        run_fetch(32'h304, 1'b0);

        // Reset in the middle of a refill abandons the line and all others.
        start_fetch(32'h0);
        guard = 0;
        while (addr_q.size() < 2 && guard < 20) begin
            tick();
            guard++;
        end
        rst_in = 1'b1;
        bus.fetch_req = 1'b0;
        bus.mem_ready = 1'b0;
        @(negedge clk_in);
        check("midrst_mem_req", {31'b0, bus.mem_req}, 0);
        check("midrst_fetch_ready", {31'b0, bus.fetch_ready}, 0);
        check("midrst_fetch_inst", bus.fetch_inst, 0);
        rst_in = 1'b0;
        @(negedge clk_in);
        check("postrst_mem_req", {31'b0, bus.mem_req}, 0);
        check("postrst_fetch_ready", {31'b0, bus.fetch_ready}, 0);
        model_reset();
        model_access(32'h0, m);
        run_fetch(32'h0, m);
        model_access(32'h44, m);
        run_fetch(32'h44, m);

        // Random fetches over 4 tags x 16 lines with variable memory latency.
        rand_lat = 1'b1;
        for (int r = 0; r < 80; r++) begin
            logic [31:0] pc;
            pc = 32'($urandom_range(0, 1023)) & 32'hFFFF_FFFC;
            model_access(pc, m);
            run_fetch(pc, m);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
